fpu_sp_norm_round: RTL and testbench

FPU_SP_NORM_ROUND -- requirements
Module: fpu_sp_norm_round

---
 rtl/fpu_sp_pkg.sv | 18 +
 rtl/fpu_sp_lzc27.sv | 19 +
 rtl/fpu_sp_norm_round.sv | 139 +++++++++++++
 tb/tb_fpu_sp_norm_round.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_sp_pkg.sv
// Shared widths and the raw add/subtract result type for the single-precision
// normalize/round stage.
package fpu_sp_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int RAW_W   = 28;
  localparam int IEXP_W  = 10;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [RAW_W-1:0] mant;
  } raw_res_t;

endpackage

// File: rtl/fpu_sp_lzc27.sv
// Leading-zero counter for the 27-bit hidden+fraction+GRS field.
// count is 27 and zero is set when the input is all zeros.
module fpu_sp_lzc27 (
  input  logic [26:0] value,
  output logic [4:0]  count,
  output logic        zero
);

  // The highest set bit is visited last, so it decides the count.
  always_comb begin
    count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (value[i]) count = 5'(26 - i);
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/fpu_sp_norm_round.sv
// Two-stage normalize (stage 1) and round-to-nearest-even/pack (stage 2) for
// single precision. Define FPU_SP_FLAGS_EN to add the out_flags port and its logic.
module fpu_sp_norm_round
  import fpu_sp_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [RAW_W-1:0]  in_mant,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef FPU_SP_FLAGS_EN
  output logic [31:0]       out_result,
  output logic [2:0]        out_flags
`else
  output logic [31:0]       out_result
`endif
);

  raw_res_t            raw;
  logic [4:0]          lzc;
  logic                lz_zero;
  logic [EXP_W-1:0]    exp_m1;
  logic [4:0]          shamt;
  logic                n_sign;
  logic [IEXP_W-1:0]   n_exp;
  logic [25:0]         n_mant;

  logic                s1_valid;
  logic                s1_sign;
  logic [IEXP_W-1:0]   s1_exp;
  logic [25:0]         s1_mant;
  logic                s2_valid;
  logic                adv1;
  logic                adv2;

  logic                g, r, s, lsb, inc, carry, ovf;
  logic [FRAC_W:0]     frac_sum;
  logic [IEXP_W-1:0]   exp_fin;
  logic [31:0]         result;

  assign raw = '{sign: in_sign, exp: in_exp, mant: in_mant};

  fpu_sp_lzc27 u_lzc (
    .value (raw.mant[26:0]),
    .count (lzc),
    .zero  (lz_zero)
  );

  // Stage 1: n_mant holds fraction in [25:3] and G/R/S in [2:0]; the hidden
  // bit is implied by a non-zero exponent field.
  always_comb begin
    n_sign = raw.sign;
    n_exp  = '0;
    n_mant = '0;
    shamt  = '0;
    exp_m1 = raw.exp - 8'd1;
    if (raw.mant[27]) begin
      n_mant = {raw.mant[26:2], raw.mant[1] | raw.mant[0]};
      n_exp  = IEXP_W'(raw.exp) + 10'd1;
    end else if (lz_zero) begin
      n_sign = 1'b0;
    end else if (raw.exp == '0) begin
      n_mant = raw.mant[25:0];
    end else if ({3'b000, lzc} > exp_m1) begin
      // Shift stops at exponent 1, which encodes as a denormal with field 0.
      shamt  = exp_m1[4:0];
      n_mant = raw.mant[25:0] << shamt;
    end else begin
      shamt  = lzc;
      n_mant = raw.mant[25:0] << shamt;
      n_exp  = IEXP_W'(raw.exp) - IEXP_W'(lzc);
    end
  end

  assign adv2      = !s2_valid | out_ready;
  assign adv1      = !s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= n_sign;
        s1_exp  <= n_exp;
        s1_mant <= n_mant;
      end
    end
  end

  // Stage 2: a carry out of the fraction leaves the low 23 bits zero, and
  // also lifts a denormal into exponent 1.
  assign g        = s1_mant[2];
  assign r        = s1_mant[1];
  assign s        = s1_mant[0];
  assign lsb      = s1_mant[3];
  assign inc      = g & (r | s | lsb);
  assign frac_sum = {1'b0, s1_mant[25:3]} + {{FRAC_W{1'b0}}, inc};
  assign carry    = frac_sum[FRAC_W];
  assign exp_fin  = s1_exp + {{(IEXP_W-1){1'b0}}, carry};
  assign ovf      = exp_fin >= IEXP_W'(EXP_MAX);
  assign result   = ovf ? {s1_sign, 8'hFF, 23'h0}
                        : {s1_sign, exp_fin[EXP_W-1:0], frac_sum[FRAC_W-1:0]};

`ifdef FPU_SP_FLAGS_EN
  logic inexact;
  logic underflow;
  assign inexact   = g | r | s;
  assign underflow = !ovf && (exp_fin == '0) && inexact;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
`ifdef FPU_SP_FLAGS_EN
      out_flags  <= '0;
`endif
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result;
`ifdef FPU_SP_FLAGS_EN
        out_flags  <= {ovf, underflow, inexact};
`endif
      end
    end
  end

endmodule

// File: tb/tb_fpu_sp_norm_round.sv
// Directed-vector bench for fpu_sp_norm_round: rounding, normalization limits,
// overflow, backpressure and mid-flight reset. Flags checked when FPU_SP_FLAGS_EN.
module tb_fpu_sp_norm_round;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [27:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FPU_SP_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLK = ~CLK;

  fpu_sp_norm_round dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef FPU_SP_FLAGS_EN
    .out_result (out_result),
    .out_flags  (out_flags)
`else
    .out_result (out_result)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input logic sgn, input logic [7:0] e,
                         input logic [27:0] m, input logic [31:0] res, input logic [2:0] flg);
    int cyc;
    cyc = 0;
    @(negedge CLK);
    in_valid = 1'b1;
    in_sign  = sgn;
    in_exp   = e;
    in_mant  = m;
    @(posedge CLK);
    #1 in_valid = 1'b0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (!out_valid && cyc < 10);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'd2);
    check({tag, "_res"}, out_result, res);
`ifdef FPU_SP_FLAGS_EN
    check({tag, "_flags"}, 32'(out_flags), 32'(flg));
`else
    $display("[TB] %s flags not built (model %b)", tag, flg);
`endif
  endtask

  logic [27:0] bp_m[3]   = '{28'h4000000, 28'h8000000, 28'h4000000};
  logic        bp_s[3]   = '{1'b0, 1'b0, 1'b1};
  logic [31:0] bp_exp[3] = '{32'h3F800000, 32'h40000000, 32'hBF800000};

  initial begin
    int sent, got, cyc;
    nRST      = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FPU_SP_FLAGS_EN
    check("rst_flags", 32'(out_flags), 32'd0);
`endif
    @(negedge CLK);
    nRST = 1'b1;

    run_vec("one",        1'b0, 8'd127, 28'h4000000, 32'h3F800000, 3'b000);
    run_vec("two",        1'b0, 8'd127, 28'h8000000, 32'h40000000, 3'b000);
    run_vec("tiny",       1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000);
    run_vec("tie_even",   1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b001);
    run_vec("tie_odd",    1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001);
    run_vec("ovf_pos",    1'b0, 8'd254, 28'h8000000, 32'h7F800000, 3'b100);
    run_vec("ovf_neg",    1'b1, 8'd254, 28'h8000000, 32'hFF800000, 3'b100);
    run_vec("ovf_round",  1'b0, 8'd254, 28'h7FFFFFC, 32'h7F800000, 3'b101);
    run_vec("zero_neg",   1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b000);
    run_vec("neg_one",    1'b1, 8'd127, 28'h4000000, 32'hBF800000, 3'b000);
    run_vec("rnd_carry",  1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b001);
    run_vec("rsh_sticky", 1'b0, 8'd127, 28'h8000001, 32'h40000000, 3'b001);
    run_vec("den_exact",  1'b0, 8'd1,   28'h2000000, 32'h00400000, 3'b000);
    run_vec("den_inexact",1'b0, 8'd1,   28'h2000004, 32'h00400000, 3'b011);
    run_vec("den_limit",  1'b0, 8'd3,   28'h0800000, 32'h00400000, 3'b000);
    run_vec("den_to_norm",1'b0, 8'd1,   28'h3FFFFFC, 32'h00800000, 3'b001);
    run_vec("den_zero",   1'b0, 8'd1,   28'h0000004, 32'h00000000, 3'b011);

    // Backpressure: sink stalls for the first 4 cycles.
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 3 && cyc < 30) begin
      @(negedge CLK);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 3);
      if (sent < 3) begin
        in_sign = bp_s[sent];
        in_exp  = 8'd127;
        in_mant = bp_m[sent];
      end
      #1;
      if (cyc == 2 || cyc == 3) begin
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        check("bp_hold_result", out_result, 32'h3F800000);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d", got), out_result, bp_exp[got]);
        got++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_count", 32'(got), 32'd3);
    repeat (2) begin
      @(negedge CLK);
      check("bp_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset with both stages full.
    out_ready = 1'b0;
    @(negedge CLK);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h4000000;
    @(negedge CLK);
    in_mant = 28'h8000000;
    @(negedge CLK);
    in_valid = 1'b0;
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    check("rst_pre_ready", 32'(in_ready), 32'd0);
    #2 nRST = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", out_result, 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst_rel_ready", 32'(in_ready), 32'd1);
    run_vec("post_rst", 1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b001);
    @(negedge CLK);
    check("post_rst_drain", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
